// File: rtl/sram_bridge_pkg.sv
// rtl/sram_bridge_pkg.sv - shared limits and response entry type for the SRAM-like bridge
package sram_bridge_pkg;

  localparam int LATENCY_MAX = 4;
  localparam int DEPTH_MAX   = 16;
  localparam int DATA_W_DEF  = 32;

  // Default-width entry; the bridge overrides the width through resp_fifo's type parameter.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  is_write;
  } rsp_entry_t;

endpackage

// File: rtl/resp_fifo.sv
// rtl/resp_fifo.sv - pointer-based synchronous response FIFO with full/empty flags
module resp_fifo
  import sram_bridge_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = rsp_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_i,
  input  entry_t push_entry_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          full;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  assign wptr_d = wptr_q + {{AW{1'b0}}, push_i};
  assign rptr_d = rptr_q + {{AW{1'b0}}, pop_i & ~empty_o};

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      assert (!(push_i && full));
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q[AW-1:0]] <= push_entry_i;
    end
  end

endmodule

// File: rtl/sram_like_bridge.sv
// rtl/sram_like_bridge.sv - CPU request/response bridge onto a fixed-latency SRAM port
module sram_like_bridge
  import sram_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_wr,
  input  logic [DATA_W/8-1:0]       cpu_wstrb,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic                      cpu_addr_ok,
  output logic                      cpu_data_ok,
  output logic [DATA_W-1:0]         cpu_rdata,
  input  logic                      cpu_rsp_ready,
  output logic                      sram_en,
  output logic [DATA_W/8-1:0]       sram_wen,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_wdata,
  input  logic [DATA_W-1:0]         sram_rdata,
  output logic [$clog2(DEPTH):0]    outstanding
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              is_write;
  } entry_t;

  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] wr_q, wr_d;
  logic               accept, consume, ret_valid;
  logic               fifo_push, fifo_pop, fifo_empty;
  entry_t             ret_entry, head_entry;

  // The outstanding cap bounds in-flight plus buffered responses, so the FIFO never overflows.
  assign accept      = ~reset & cpu_req & (outstanding_q < CNT_W'(DEPTH));
  assign cpu_addr_ok = accept;
  assign sram_en     = accept;
  assign sram_addr   = cpu_addr;
  assign sram_wdata  = cpu_wdata;
  assign sram_wen    = {STRB_W{cpu_wr & accept}} & cpu_wstrb;
  assign outstanding = reset ? '0 : outstanding_q;

  always_comb begin
    vld_d    = vld_q;
    wr_d     = wr_q;
    vld_d[0] = accept;
    wr_d[0]  = cpu_wr;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      wr_d[i]  = wr_q[i-1];
    end
  end

  assign ret_valid = ~reset & vld_q[LATENCY-1];

  always_comb begin
    ret_entry          = '0;
    ret_entry.is_write = wr_q[LATENCY-1];
    ret_entry.data     = wr_q[LATENCY-1] ? '0 : sram_rdata;
  end

  // Buffered responses take priority; a fresh return only bypasses when nothing is queued.
  always_comb begin
    cpu_data_ok = 1'b0;
    cpu_rdata   = '0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    if (!reset) begin
      if (!fifo_empty) begin
        cpu_data_ok = 1'b1;
        cpu_rdata   = head_entry.is_write ? '0 : head_entry.data;
        fifo_pop    = cpu_rsp_ready;
        fifo_push   = ret_valid;
      end else if (ret_valid) begin
        cpu_data_ok = 1'b1;
        cpu_rdata   = ret_entry.data;
        fifo_push   = ~cpu_rsp_ready;
      end
    end
    consume = cpu_data_ok & cpu_rsp_ready;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, consume})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    assert (LATENCY >= 1 && LATENCY <= LATENCY_MAX && DEPTH >= 2 && DEPTH <= DEPTH_MAX);
    if (reset) begin
      outstanding_q <= '0;
      vld_q         <= '0;
      wr_q          <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      vld_q         <= vld_d;
      wr_q          <= wr_d;
    end
  end

  resp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_resp_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (fifo_push),
    .push_entry_i (ret_entry),
    .pop_i        (fifo_pop),
    .head_o       (head_entry),
    .empty_o      (fifo_empty)
  );

endmodule

// File: tb/tb_sram_like_bridge.sv
// tb/tb_sram_like_bridge.sv - directed scoreboard bench for sram_like_bridge
module tb_sram_like_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cpu_req, cpu_wr, cpu_rsp_ready;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_addr, cpu_wdata;

  logic        d1_addr_ok, d1_data_ok, d1_sram_en;
  logic [31:0] d1_rdata, d1_sram_addr, d1_sram_wdata, d1_sram_rdata;
  logic [3:0]  d1_sram_wen;
  logic [2:0]  d1_outstanding;

  logic        d3_addr_ok, d3_data_ok, d3_sram_en;
  logic [31:0] d3_rdata, d3_sram_addr, d3_sram_wdata, d3_sram_rdata;
  logic [3:0]  d3_sram_wen;
  logic [2:0]  d3_outstanding;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb_q[$];
  int model_out = 0;

  sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .DEPTH(4)) u_dut1 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_wstrb(cpu_wstrb),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_addr_ok(d1_addr_ok), .cpu_data_ok(d1_data_ok),
    .cpu_rdata(d1_rdata), .cpu_rsp_ready(cpu_rsp_ready), .sram_en(d1_sram_en), .sram_wen(d1_sram_wen),
    .sram_addr(d1_sram_addr), .sram_wdata(d1_sram_wdata), .sram_rdata(d1_sram_rdata),
    .outstanding(d1_outstanding)
  );

  sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .LATENCY(3), .DEPTH(4)) u_dut3 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_wstrb(cpu_wstrb),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_addr_ok(d3_addr_ok), .cpu_data_ok(d3_data_ok),
    .cpu_rdata(d3_rdata), .cpu_rsp_ready(cpu_rsp_ready), .sram_en(d3_sram_en), .sram_wen(d3_sram_wen),
    .sram_addr(d3_sram_addr), .sram_wdata(d3_sram_wdata), .sram_rdata(d3_sram_rdata),
    .outstanding(d3_outstanding)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
  endfunction

  // SRAM models: data for the enabled address appears LATENCY cycles later.
  logic [31:0] s1_pipe;
  logic [31:0] s3_pipe [3];
  always @(posedge clk) begin
    s1_pipe    <= d1_sram_en ? data_of(d1_sram_addr) : 32'hBAD0BAD0;
    s3_pipe[0] <= d3_sram_en ? data_of(d3_sram_addr) : 32'hBAD0BAD0;
    s3_pipe[1] <= s3_pipe[0];
    s3_pipe[2] <= s3_pipe[1];
  end
  assign d1_sram_rdata = s1_pipe;
  assign d3_sram_rdata = s3_pipe[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard on the LATENCY=3 instance: responses must match acceptance order.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      model_out = 0;
    end else begin
      chk("sb_addr_ok", d3_addr_ok, (cpu_req && model_out < 4));
      chk("sb_outstanding", d3_outstanding, model_out);
      if (d3_data_ok) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_rsp", d3_data_ok, 1'b0);
        end else begin
          chk("sb_rdata", d3_rdata, sb_q[0]);
          if (cpu_rsp_ready) void'(sb_q.pop_front());
        end
      end
      if (d3_addr_ok) sb_q.push_back(cpu_wr ? 32'h0 : data_of(cpu_addr));
      model_out = model_out + (d3_addr_ok ? 1 : 0) - ((d3_data_ok && cpu_rsp_ready) ? 1 : 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_wstrb = 4'h0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_rsp_ready = 1'b1;
    tick(); tick();
    cpu_req = 1'b1; cpu_addr = 32'h40;
    mid();
    chk("rst_addr_ok", d3_addr_ok, 1'b0);
    chk("rst_sram_en", d3_sram_en, 1'b0);
    chk("rst_data_ok", d3_data_ok, 1'b0);
    chk("rst_outstanding", d3_outstanding, 3'd0);
    chk("rst_d1_addr_ok", d1_addr_ok, 1'b0);
    tick();
    reset = 1'b0; cpu_req = 1'b0;
    tick(); tick();

    // Single read: LATENCY=1 bypass and LATENCY=3 arrival.
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h100;
    mid();
    chk("rd_addr_ok", d1_addr_ok, 1'b1);
    chk("rd_sram_addr", d1_sram_addr, 32'h100);
    chk("rd_sram_wen", d3_sram_wen, 4'h0);
    tick(); cpu_req = 1'b0;
    mid();
    chk("rd_lat1_data_ok", d1_data_ok, 1'b1);
    chk("rd_lat1_rdata", d1_rdata, 32'hDEADBEEF);
    chk("rd_lat3_early", d3_data_ok, 1'b0);
    tick(); tick();
    mid();
    chk("rd_lat3_data_ok", d3_data_ok, 1'b1);
    chk("rd_lat3_rdata", d3_rdata, 32'hDEADBEEF);
    tick();
    mid();
    chk("idle_data_ok", d3_data_ok, 1'b0);
    chk("idle_rdata", d3_rdata, 32'h0);
    chk("idle_d1_outstanding", d1_outstanding, 3'd0);
    tick();

    // Partial-strobe write returns zero data.
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_wstrb = 4'b0011; cpu_addr = 32'h8; cpu_wdata = 32'h12345678;
    mid();
    chk("wr_sram_wen", d3_sram_wen, 4'b0011);
    chk("wr_sram_wdata", d3_sram_wdata, 32'h12345678);
    chk("wr_d1_sram_wen", d1_sram_wen, 4'b0011);
    tick(); cpu_req = 1'b0; cpu_wr = 1'b0; cpu_wstrb = 4'h0;
    mid();
    chk("wr_lat1_data_ok", d1_data_ok, 1'b1);
    chk("wr_lat1_rdata", d1_rdata, 32'h0);
    tick(); tick();
    mid();
    chk("wr_lat3_data_ok", d3_data_ok, 1'b1);
    chk("wr_lat3_rdata", d3_rdata, 32'h0);
    tick(); tick();

    // Back-to-back reads with the consumer stalled: fill to DEPTH, then drain.
    cpu_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_addr = 32'h200 + 32'(4 * i);
      mid();
      chk("burst_accept", d3_addr_ok, 1'b1);
      tick();
    end
    cpu_addr = 32'h210;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("burst_full_addr_ok", d3_addr_ok, 1'b0);
      chk("burst_full_outstanding", d3_outstanding, 3'd4);
      tick();
    end
    cpu_rsp_ready = 1'b1;
    mid();
    chk("full_consume_addr_ok", d3_addr_ok, 1'b0);
    chk("full_consume_rdata", d3_rdata, data_of(32'h200));
    tick();
    mid();
    chk("after_consume_addr_ok", d3_addr_ok, 1'b1);
    chk("after_consume_outstanding", d3_outstanding, 3'd3);
    tick(); cpu_addr = 32'h214;
    mid();
    chk("acc_and_consume_outstanding", d3_outstanding, 3'd3);
    chk("burst_last_accept", d3_addr_ok, 1'b1);
    tick(); cpu_req = 1'b0;
    mid();
    chk("acc_and_consume_outstanding2", d3_outstanding, 3'd3);
    tick();
    mid();
    chk("drain_outstanding", d3_outstanding, 3'd2);
    chk("drain_bypass_rdata", d3_rdata, data_of(32'h210));
    tick(); tick(); tick();
    mid();
    chk("burst_done_outstanding", d3_outstanding, 3'd0);
    tick();

    // Reset with three requests in flight.
    cpu_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1'b1; cpu_addr = 32'h300 + 32'(4 * i);
      mid();
      chk("flight_accept", d3_addr_ok, 1'b1);
      tick();
    end
    cpu_req = 1'b0; reset = 1'b1;
    mid();
    chk("midrst_outstanding", d3_outstanding, 3'd0);
    chk("midrst_data_ok", d3_data_ok, 1'b0);
    tick();
    reset = 1'b0; cpu_rsp_ready = 1'b1;
    cpu_req = 1'b1; cpu_addr = 32'h400;
    mid();
    chk("postrst_outstanding", d3_outstanding, 3'd0);
    chk("postrst_accept", d3_addr_ok, 1'b1);
    chk("postrst_no_stale_d1", d1_data_ok, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        tick(); cpu_req = 1'b0;
      end else begin
        tick();
      end
      if (k < 2) begin
        mid();
        chk("postrst_no_stale", d3_data_ok, 1'b0);
      end
    end
    mid();
    chk("postrst_rsp_ok", d3_data_ok, 1'b1);
    chk("postrst_rsp_rdata", d3_rdata, data_of(32'h400));
    tick(); tick();
    mid();
    chk("final_outstanding", d3_outstanding, 3'd0);
    chk("final_d1_outstanding", d1_outstanding, 3'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
